// File: rtl/fp_pkg.sv
// Shared single-precision field definitions, helpers and the subtractor state type.
// FP_SUB_ROUND_EN adds the ROUND state for round-to-nearest-even.
package fp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned SIG_W  = MANT_W + 1;
    // Working mantissa: carry, 24-bit significand, guard, round, sticky.
    localparam int unsigned WORK_W = SIG_W + 4;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

`ifdef FP_SUB_ROUND_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd5
    } state_e;
`endif

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [FP_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

    function automatic logic [FP_W-1:0] fp_pack(input logic             sign,
                                                input logic [EXP_W-1:0]  exp,
                                                input logic [MANT_W-1:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational alignment shifter: 24-bit significand right-shifted by an 8-bit
// amount, with guard/round/sticky of the bits shifted out.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    input  logic [EXP_W-1:0] amt_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [2:0]       grs_o
);

    localparam int unsigned FRAC_W = SIG_W + 2;
    localparam int unsigned WIDE_W = SIG_W + FRAC_W;

    logic [WIDE_W-1:0] wide;

    // Shifts up to FRAC_W keep every bit inside wide; beyond that only sticky survives.
    always_comb begin
        wide  = '0;
        sig_o = '0;
        grs_o = '0;
        if (amt_i <= EXP_W'(FRAC_W)) begin
            wide  = {sig_i, FRAC_W'(0)} >> amt_i[4:0];
            sig_o = wide[WIDE_W-1 -: SIG_W];
            grs_o = {wide[FRAC_W-1], wide[FRAC_W-2], |wide[FRAC_W-3:0]};
        end else begin
            grs_o = {2'b00, |sig_i};
        end
    end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = a - b) with
// valid/ready on both sides; FP_SUB_ROUND_EN enables round-to-nearest-even.
module fp_subtractor_seq
    import fp_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] result,
    output logic         out_valid,
    input  logic         out_ready
);

`ifdef FP_SUB_ROUND_EN
    localparam bit     ROUND_EN = 1'b1;
    localparam state_e LEAVE_ST = ROUND;
`else
    localparam bit     ROUND_EN = 1'b0;
    localparam state_e LEAVE_ST = DONE;
`endif

    state_e             state_q, state_d;
    logic [N-1:0]       a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   sig_l_q, sig_l_d, sig_s_q, sig_s_d;
    logic [2:0]         grs_s_q, grs_s_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [N-1:0]       result_q, result_d;
    logic               in_ready_q, out_valid_q;

    logic               a_ge_b;
    logic [N-1:0]       op_l, op_s;
    logic [SIG_W-1:0]   sig_sh;
    logic [2:0]         grs_sh, grs_used;
    logic [EXP_W-1:0]   exp_inc;
    logic               leave;

    // Magnitude ordering; b_q already carries the flipped sign.
    assign a_ge_b   = (a_q[N-2:0] >= b_q[N-2:0]);
    assign op_l     = a_ge_b ? a_q : b_q;
    assign op_s     = a_ge_b ? b_q : a_q;
    assign grs_used = ROUND_EN ? grs_sh : 3'b000;
    assign exp_inc  = exp_q + 8'd1;

    fp_align_shifter u_align (
        .sig_i (SIG_W'({1'b1, fp_mant(op_s)})),
        .amt_i (fp_exp(op_l) - fp_exp(op_s)),
        .sig_o (sig_sh),
        .grs_o (grs_sh)
    );

`ifdef FP_SUB_ROUND_EN
    logic               rnd_up;
    logic [SIG_W:0]     rnd_sum;
    assign rnd_up  = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
    assign rnd_sum = {1'b0, work_q[WORK_W-2:3]} + (SIG_W+1)'(rnd_up);
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_l_d  = sig_l_q;
        sig_s_d  = sig_s_q;
        grs_s_d  = grs_s_q;
        work_d   = work_q;
        result_d = result_q;
        leave    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {~b[N-1], b[N-2:0]};
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (fp_is_zero(b_q)) begin
                    result_d = a_q;
                    state_d  = DONE;
                end else if (fp_is_zero(a_q)) begin
                    result_d = b_q;
                    state_d  = DONE;
                end else begin
                    sign_d  = op_l[N-1];
                    exp_d   = fp_exp(op_l);
                    sig_l_d = {1'b1, fp_mant(op_l)};
                    sig_s_d = sig_sh;
                    grs_s_d = grs_used;
                    state_d = ADDSUB;
                end
            end
            ADDSUB: begin
                if (a_q[N-1] == b_q[N-1]) begin
                    work_d = {1'b0, sig_l_q, 3'b000} + {1'b0, sig_s_q, grs_s_q};
                end else begin
                    work_d = {1'b0, sig_l_q, 3'b000} - {1'b0, sig_s_q, grs_s_q};
                end
                state_d = NORM;
            end
            // One normalisation step per cycle.
            NORM: begin
                if (work_q[WORK_W-1]) begin
                    work_d = {1'b0, work_q[WORK_W-1:2], |work_q[1:0]};
                    exp_d  = exp_inc;
                    if (exp_inc == EXP_MAX) begin
                        result_d = fp_pack(sign_q, EXP_MAX, '0);
                        state_d  = DONE;
                    end else begin
                        leave = 1'b1;
                    end
                end else if (work_q[WORK_W-2:0] == '0) begin
                    result_d = '0;
                    state_d  = DONE;
                end else if (work_q[WORK_W-2]) begin
                    leave = 1'b1;
                end else if (exp_q == 8'd1) begin
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    work_d = {work_q[WORK_W-2:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                end
            end
`ifdef FP_SUB_ROUND_EN
            ROUND: begin
                if (rnd_sum[SIG_W]) begin
                    result_d = (exp_inc == EXP_MAX) ? fp_pack(sign_q, EXP_MAX, '0)
                                                    : fp_pack(sign_q, exp_inc, rnd_sum[MANT_W:1]);
                end else begin
                    result_d = fp_pack(sign_q, exp_q, rnd_sum[MANT_W-1:0]);
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (leave) begin
            state_d = LEAVE_ST;
`ifndef FP_SUB_ROUND_EN
            result_d = fp_pack(sign_q, exp_d, work_d[WORK_W-3 -: MANT_W]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_l_q     <= '0;
            sig_s_q     <= '0;
            grs_s_q     <= '0;
            work_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_l_q     <= sig_l_d;
            sig_s_q     <= sig_s_d;
            grs_s_q     <= grs_s_d;
            work_q      <= work_d;
            result_q    <= result_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed self-checking bench for fp_subtractor_seq: vector table plus
// backpressure and mid-operation reset sequences.
module tb_fp_subtractor_seq;

`ifdef FP_SUB_ROUND_EN
    localparam int XLAT = 1;
`else
    localparam int XLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[12];

    fp_subtractor_seq #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents operands for one edge; returns just after the accept edge.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
        @(negedge clk);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'hDEADBEEF;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] exp_r, input int exp_lat, input string name);
        int lat;
        start_op(ta, tb_v);
        check({name, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(name, lat);
        if (exp_lat != 0) check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, result, exp_r);
        drain(name);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 4 + XLAT, "sub3m1"};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 4,        "equal"};
        vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 4 + XLAT, "carry"};
        vecs[3]  = '{32'h3F800000, 32'h3F400000, 32'h3E800000, 6 + XLAT, "norm2"};
        vecs[4]  = '{32'h40A00000, 32'h00000000, 32'h40A00000, 2,        "bzero"};
        vecs[5]  = '{32'h00000000, 32'h40A00000, 32'hC0A00000, 2,        "azero"};
        vecs[6]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 5 + XLAT, "negres"};
        vecs[7]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4,        "ovf"};
        vecs[8]  = '{32'h00800000, 32'h00C00000, 32'h00000000, 4,        "uflow"};
        vecs[9]  = '{32'h4C000000, 32'h3F800000, 32'h4C000000, (XLAT != 0) ? 6 : 4, "far"};
        vecs[10] = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 4 + XLAT, "negneg"};
        vecs[11] = '{32'h40200000, 32'h3F000000, 32'h40000000, 4 + XLAT, "frac"};

        rst_n = 1'b0;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_result", result, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].lat, vecs[i].name);
        end

        // Backpressure with a competing request offered while DONE.
        start_op(32'h40400000, 32'h3F800000);
        wait_valid("bp", lat);
        check("bp_res0", result, 32'h40000000);
        a = 32'h3F800000;
        b = 32'h3F400000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_res", result, 32'h40000000);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_not_captured", 32'(in_ready), 32'd1);
        run_op(32'h3F800000, 32'h3F400000, 32'h3E800000, 6 + XLAT, "bp_next");

        // Reset while in NORM.
        start_op(32'h3F800000, 32'h3F400000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstn_result", result, 32'h0);
        check("rstn_valid", 32'(out_valid), 32'd0);
        check("rstn_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4 + XLAT, "after_rst");

        // Reset while holding a result in DONE.
        start_op(32'h40A00000, 32'h00000000);
        wait_valid("rstd", lat);
        check("rstd_res0", result, 32'h40A00000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstd_result", result, 32'h0);
        check("rstd_valid", 32'(out_valid), 32'd0);
        check("rstd_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3F800000, 32'h40000000, 32'hBF800000, 5 + XLAT, "after_rstd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
